// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Registered program counter for the fetch stage with integrated next-PC
// selection (sequential, beq/bne, j/jal, jr/jalr, exception entry and eret),
// an exception-PC register and a small circular return-address stack (RAS)
// that predicts jr $ra targets.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous reset, active-high
//   stall      in   1       hold PC, EPC and RAS (exceptions and eret still act)
//   imm16      in   16      signed branch offset in words
//   target26   in   26      jump target field
//   rs_data    in   ADDR_W  jr/jalr target register value
//   branch     in   1       conditional branch instruction
//   br_ne      in   1       1 = bne, 0 = beq
//   zero       in   1       ALU zero flag
//   jump       in   1       j/jal
//   jr         in   1       jr/jalr
//   rs_is_ra   in   1       jr source is $31 (RAS pop)
//   link       in   1       jal/jalr (RAS push of pc+4)
//   exc        in   1       external exception request
//   eret       in   1       return from exception
//   pc         out  ADDR_W  current PC (registered)
//   pc_plus4   out  ADDR_W  pc + 4 (combinational)
//   epc        out  ADDR_W  saved exception PC (registered)
//   exc_cause  out  2       00 none, 01 external, 10 jr misaligned (registered)
//   ras_top    out  ADDR_W  RAS top entry, 0 when empty
//   ras_empty  out  1       RAS holds no entries
//   ras_hit    out  1       last accepted pop matched rs_data (registered)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_4180),
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [15:0]       imm16,
    input  logic [25:0]       target26,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic              branch,
    input  logic              br_ne,
    input  logic              zero,
    input  logic              jump,
    input  logic              jr,
    input  logic              rs_is_ra,
    input  logic              link,
    input  logic              exc,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] epc,
    output logic [1:0]        exc_cause,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_hit
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_EXT  = 2'b01;
    localparam logic [1:0] CAUSE_JRMA = 2'b10;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_JR,
        SEL_ERET,
        SEL_EXC,
        SEL_HOLD
    } pc_sel_e;

    // Architectural state
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] epc_r;
    logic [1:0]        cause_r;
    logic              hit_r;
    logic [PTR_W-1:0]  ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] mem_r [RAS_DEPTH];

    // Next-state / decode
    pc_sel_e           sel_s;
    logic [ADDR_W-1:0] pc_plus4_s;
    logic [ADDR_W-1:0] br_off_s;
    logic [ADDR_W-1:0] br_tgt_s;
    logic [ADDR_W-1:0] jmp_tgt_s;
    logic [ADDR_W-1:0] hi_mask_s;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [ADDR_W-1:0] epc_nxt_s;
    logic [1:0]        cause_nxt_s;
    logic              misalign_s;
    logic              exc_take_s;
    logic              br_taken_s;
    logic              pop_req_s;
    logic              empty_s;
    logic              full_s;
    logic [ADDR_W-1:0] top_s;
    logic [PTR_W-1:0]  ptr_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              hit_nxt_s;
    logic              wr_en_s;
    logic [PTR_W-1:0]  wr_idx_s;

    // Target arithmetic; all sums wrap modulo 2^ADDR_W
    assign pc_plus4_s = pc_r + ADDR_W'(32'd4);
    assign br_off_s   = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    assign br_tgt_s   = pc_plus4_s + br_off_s;
    // Jump keeps the region bits above bit 27 of pc+4 (none when ADDR_W is 28)
    assign hi_mask_s  = {ADDR_W{1'b1}} << 28;
    assign jmp_tgt_s  = (pc_plus4_s & hi_mask_s) | ADDR_W'({target26, 2'b00});

    assign misalign_s = jr & (rs_data[1:0] != 2'b00);
    assign exc_take_s = exc | misalign_s;
    assign br_taken_s = branch & (br_ne ? ~zero : zero);
    assign pop_req_s  = jr & rs_is_ra;

    assign empty_s    = (cnt_r == CNT_W'(0));
    assign full_s     = (cnt_r == CNT_W'(RAS_DEPTH));
    assign top_s      = empty_s ? {ADDR_W{1'b0}} : mem_r[ptr_r];

    // Next-PC source selection in priority order; exception and eret override stall
    always_comb begin
        sel_s = SEL_SEQ;
        if (exc_take_s) begin
            sel_s = SEL_EXC;
        end else if (eret) begin
            sel_s = SEL_ERET;
        end else if (stall) begin
            sel_s = SEL_HOLD;
        end else if (jr) begin
            sel_s = SEL_JR;
        end else if (jump) begin
            sel_s = SEL_JMP;
        end else if (br_taken_s) begin
            sel_s = SEL_BR;
        end else begin
            sel_s = SEL_SEQ;
        end
    end

    // PC / EPC / cause next values from the selected source
    always_comb begin
        pc_nxt_s    = pc_plus4_s;
        epc_nxt_s   = epc_r;
        cause_nxt_s = cause_r;
        case (sel_s)
            SEL_EXC: begin
                pc_nxt_s    = EXC_VEC;
                epc_nxt_s   = pc_r;
                cause_nxt_s = exc ? CAUSE_EXT : CAUSE_JRMA;
            end
            SEL_ERET: begin
                pc_nxt_s    = epc_r;
                cause_nxt_s = CAUSE_NONE;
            end
            SEL_HOLD: pc_nxt_s = pc_r;
            SEL_JR:   pc_nxt_s = rs_data;
            SEL_JMP:  pc_nxt_s = jmp_tgt_s;
            SEL_BR:   pc_nxt_s = br_tgt_s;
            SEL_SEQ:  pc_nxt_s = pc_plus4_s;
            default:  pc_nxt_s = pc_plus4_s;
        endcase
    end

    // RAS next state: pointer always addresses the top entry, count saturates
    always_comb begin
        ptr_nxt_s = ptr_r;
        cnt_nxt_s = cnt_r;
        hit_nxt_s = hit_r;
        wr_en_s   = 1'b0;
        wr_idx_s  = ptr_r;
        if ((sel_s == SEL_EXC) || (sel_s == SEL_ERET)) begin
            hit_nxt_s = 1'b0;
        end else if (sel_s == SEL_HOLD) begin
            hit_nxt_s = hit_r;
        end else begin
            case ({link, pop_req_s})
                2'b10: begin
                    // Push; when full the slot after the top is the oldest entry
                    ptr_nxt_s = ptr_r + PTR_W'(1);
                    wr_en_s   = 1'b1;
                    wr_idx_s  = ptr_r + PTR_W'(1);
                    cnt_nxt_s = full_s ? cnt_r : (cnt_r + CNT_W'(1));
                end
                2'b01: begin
                    if (!empty_s) begin
                        ptr_nxt_s = ptr_r - PTR_W'(1);
                        cnt_nxt_s = cnt_r - CNT_W'(1);
                        hit_nxt_s = (top_s == rs_data);
                    end else begin
                        hit_nxt_s = 1'b0;
                    end
                end
                2'b11: begin
                    if (!empty_s) begin
                        // jalr $ra: replace top in place, compare against old top
                        wr_en_s   = 1'b1;
                        wr_idx_s  = ptr_r;
                        hit_nxt_s = (top_s == rs_data);
                    end else begin
                        // Nothing to pop, so the link behaves as a plain push
                        ptr_nxt_s = ptr_r + PTR_W'(1);
                        wr_en_s   = 1'b1;
                        wr_idx_s  = ptr_r + PTR_W'(1);
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                        hit_nxt_s = 1'b0;
                    end
                end
                default: begin
                    hit_nxt_s = hit_r;
                end
            endcase
        end
    end

    // Control and PC state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= RESET_VEC;
            epc_r   <= {ADDR_W{1'b0}};
            cause_r <= CAUSE_NONE;
            hit_r   <= 1'b0;
            ptr_r   <= {PTR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            pc_r    <= pc_nxt_s;
            epc_r   <= epc_nxt_s;
            cause_r <= cause_nxt_s;
            hit_r   <= hit_nxt_s;
            ptr_r   <= ptr_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // RAS entry storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_r[i] <= {ADDR_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_idx_s] <= pc_plus4_s;
        end else begin
            mem_r[wr_idx_s] <= mem_r[wr_idx_s];
        end
    end

    assign pc        = pc_r;
    assign pc_plus4  = pc_plus4_s;
    assign epc       = epc_r;
    assign exc_cause = cause_r;
    assign ras_top   = top_s;
    assign ras_empty = empty_s;
    assign ras_hit   = hit_r;

endmodule
